// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, opcode field width and the
// opcode that terminates fetch.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;

    localparam int OP_W = 6;
    typedef logic [OP_W-1:0] opcode_t;

    localparam opcode_t HALT_OPCODE = 6'b111111;

endpackage

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: a small circular FIFO of {instr, npc}
// that also tracks a fetched HALT (stops fetch) and a retired HALT (halt out).
module if_id_queue
    import cpu_types_pkg::*;
#(
    parameter int      DEPTH   = 4,
    parameter int      IW      = $bits(word_t),
    parameter int      PW      = $bits(word_t),
    parameter opcode_t HALT_OP = HALT_OPCODE
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     ihit,
    input  logic [IW-1:0]            instr,
    input  logic [PW-1:0]            npc,
    input  logic                     deq,
    input  logic                     flush,
    output logic [IW-1:0]            instr_out,
    output logic [PW-1:0]            npc_out,
    output logic                     valid_out,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     fetch_stall,
    output logic                     halt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [IW-1:0]    instr_mem_q [DEPTH];
    logic [IW-1:0]    instr_mem_d [DEPTH];
    logic [PW-1:0]    npc_mem_q   [DEPTH];
    logic [PW-1:0]    npc_mem_d   [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             halt_seen_q, halt_seen_d;
    logic             halt_q, halt_d;

    logic             enq_ok, deq_ok;
    logic             empty;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign valid_out = !empty;
    assign count     = count_q;
    assign halt      = halt_q;

    assign fetch_stall = full || halt_seen_q;

    // Full is judged on the current occupancy, so a same-cycle dequeue never
    // frees a slot for the incoming instruction.
    assign enq_ok = ihit && !full && !halt_seen_q && !flush;
    assign deq_ok = deq && valid_out && !flush;

    assign instr_out = empty ? '0 : instr_mem_q[rd_ptr_q];
    assign npc_out   = empty ? '0 : npc_mem_q[rd_ptr_q];

    always_comb begin
        instr_mem_d = instr_mem_q;
        npc_mem_d   = npc_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        halt_seen_d = halt_seen_q;
        halt_d      = halt_q;

        if (enq_ok) begin
            instr_mem_d[wr_ptr_q] = instr;
            npc_mem_d[wr_ptr_q]   = npc;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            if (instr[IW-1 -: OP_W] == HALT_OP)
                halt_seen_d = 1'b1;
        end

        if (deq_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (instr_mem_q[rd_ptr_q][IW-1 -: OP_W] == HALT_OP)
                halt_d = 1'b1;
        end

        if (enq_ok && !deq_ok)
            count_d = count_q + CW'(1);
        else if (deq_ok && !enq_ok)
            count_d = count_q - CW'(1);

        // Redirect empties the queue and re-arms fetch; a retired halt stays.
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            halt_seen_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                npc_mem_q[i]   <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            halt_seen_q <= 1'b0;
            halt_q      <= 1'b0;
        end else begin
            instr_mem_q <= instr_mem_d;
            npc_mem_q   <= npc_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            halt_seen_q <= halt_seen_d;
            halt_q      <= halt_d;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue (DEPTH=4) with hand-computed expectations.
module tb_if_id_queue;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, deq, flush;
    logic [31:0] instr, npc;
    logic [31:0] instr_out, npc_out;
    logic        valid_out, full, fetch_stall, halt;
    logic [2:0]  count;

    int n_chk  = 0;
    int n_pass = 0;

    if_id_queue #(.DEPTH(4), .IW(32), .PW(32)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .instr(instr), .npc(npc),
        .deq(deq), .flush(flush), .instr_out(instr_out), .npc_out(npc_out),
        .valid_out(valid_out), .full(full), .count(count),
        .fetch_stall(fetch_stall), .halt(halt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Inputs are set before the call; outputs are stable 1ns after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ihit = 0; deq = 0; flush = 0;
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] p);
        ihit = 1; instr = i; npc = p; deq = 0; flush = 0;
        step();
        idle();
    endtask

    task automatic pop();
        ihit = 0; deq = 1; flush = 0;
        step();
        idle();
    endtask

    // Interleave pattern for the wrap test (bit k = cycle k)
    logic [9:0]  ih_pat = 10'b1101111011;
    logic [9:0]  dq_pat = 10'b1111010101;
    logic [31:0] model_q[$];
    logic [31:0] nxt;

    initial begin
        idle(); instr = 0; npc = 0;
        nRST = 0;
        #12;
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_stall", 32'(fetch_stall), 0);
        chk("rst_halt", 32'(halt), 0);
        chk("rst_instr", instr_out, 0);
        chk("rst_npc", npc_out, 0);
        nRST = 1;
        step();

        // single enqueue, one-cycle latency
        push(32'h8C010004, 32'h4);
        chk("one_valid", 32'(valid_out), 1);
        chk("one_instr", instr_out, 32'h8C010004);
        chk("one_npc", npc_out, 32'h4);
        chk("one_count", 32'(count), 1);
        pop();
        chk("one_empty", 32'(valid_out), 0);
        pop(); // deq while empty
        chk("underflow_count", 32'(count), 0);

        // fill to full, 5th rejected, drain in order
        for (int k = 0; k < 5; k++) push(32'h1000 + k, 32'(4 * k));
        chk("fill_count", 32'(count), 4);
        chk("fill_full", 32'(full), 1);
        chk("fill_stall", 32'(fetch_stall), 1);
        for (int k = 0; k < 4; k++) begin
            chk("drain_instr", instr_out, 32'h1000 + k);
            chk("drain_npc", npc_out, 32'(4 * k));
            pop();
        end
        chk("drain_empty", 32'(valid_out), 0);

        // full with ihit+deq: deq only
        for (int k = 0; k < 4; k++) push(32'h2000 + k, 32'h0);
        ihit = 1; deq = 1; instr = 32'h2FFF;
        step(); idle();
        chk("fulldeq_count", 32'(count), 3);
        chk("fulldeq_head", instr_out, 32'h2001);
        for (int k = 1; k < 4; k++) begin
            chk("fulldeq_drain", instr_out, 32'h2000 + k);
            pop();
        end
        chk("fulldeq_empty", 32'(valid_out), 0);

        // flush with concurrent ihit
        push(32'h3000, 0); push(32'h3001, 0);
        ihit = 1; flush = 1; instr = 32'h3002;
        step(); idle();
        chk("flush_count", 32'(count), 0);
        chk("flush_valid", 32'(valid_out), 0);
        push(32'h3003, 32'h30);
        chk("postflush_head", instr_out, 32'h3003);
        chk("postflush_count", 32'(count), 1);
        pop();

        // halt handling
        push(32'hFFFFFFFF, 32'h40);
        chk("halt_stall", 32'(fetch_stall), 1);
        push(32'h00000020, 32'h44);
        chk("halt_block", 32'(count), 1);
        chk("halt_pre", 32'(halt), 0);
        pop();
        chk("halt_set", 32'(halt), 1);
        step(); step();
        chk("halt_sticky", 32'(halt), 1);
        flush = 1; step(); idle();
        chk("flush_unstall", 32'(fetch_stall), 0);
        chk("flush_keeps_halt", 32'(halt), 1);

        // interleaved enq/deq with wrap, against a queue model
        nxt = 32'h5000;
        for (int c = 0; c < 10; c++) begin
            logic e, d;
            ihit = ih_pat[c]; deq = dq_pat[c]; instr = nxt; npc = 0;
            e = ih_pat[c] && (model_q.size() < 4);
            d = dq_pat[c] && (model_q.size() > 0);
            step();
            if (d) void'(model_q.pop_front());
            if (e) begin model_q.push_back(nxt); nxt++; end
            chk("wrap_count", 32'(count), 32'(model_q.size()));
            chk("wrap_head", instr_out, (model_q.size() > 0) ? model_q[0] : 32'h0);
        end
        idle();

        // asynchronous reset mid-operation
        push(32'h6000, 0); push(32'h6001, 0);
        #2 nRST = 0;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_valid", 32'(valid_out), 0);
        chk("arst_halt", 32'(halt), 0);
        nRST = 1;
        step();
        chk("arst_after", 32'(count), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-002 Parameter IW, default 32, instruction width.
REQ-003 Parameter PW, default 32, PC width.
REQ-004 Parameter HALT_OP, default 6'b111111, opcode (instr[31:26]) that stops fetch.
REQ-005 CLK  input  1  single clock; all state updates on rising edge.
REQ-006 nRST  input  1  asynchronous, active-low reset.
REQ-007 ihit  input  1  fetch has a valid instruction this cycle (enqueue request).
REQ-008 instr  input  IW  fetched instruction.
REQ-009 npc  input  PW  PC+4 of the fetched instruction.
REQ-010 deq  input  1  decode consumes head entry this cycle.
REQ-011 flush  input  1  branch/jump redirect; discard all entries.
REQ-012 instr_out  output  IW  head instruction; 0 when empty.
REQ-013 npc_out  output  PW  head PC+4; 0 when empty.
REQ-014 valid_out  output  1  head entry valid (= not empty).
REQ-015 full  output  1  count == DEPTH.
REQ-016 count  output  $clog2(DEPTH)+1  occupied entries.
REQ-017 fetch_stall  output  1  full OR halt_seen; fetch must hold PC.
REQ-018 halt  output  1  registered; pulses one cycle after a HALT_OP head is dequeued, then stays high.

Function
REQ-019 Enqueue accepted iff ihit && !full && !halt_seen && !flush; writes {instr,npc} at wr_ptr, wr_ptr increments.
REQ-020 Dequeue accepted iff deq && valid_out && !flush; rd_ptr increments.
REQ-021 Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 without extra logic.
REQ-022 count updates +1 (enq only), -1 (deq only), unchanged (both or neither).
REQ-023 Full with deq and ihit same cycle: enqueue rejected (full evaluated before deq); no pass-through.
REQ-024 Empty with ihit and deq same cycle: deq ignored; entry appears at head next cycle (one-cycle latency).
REQ-025 deq while empty: no effect, no underflow.
REQ-026 halt_seen sets on accepted enqueue of instr[31:26] == HALT_OP; blocks all later enqueues.
REQ-027 halt sets on accepted dequeue of a HALT_OP head; sticky until reset.
REQ-028 flush: next cycle wr_ptr = rd_ptr = 0, count = 0, halt_seen = 0; same-cycle enq/deq discarded; halt unaffected.
REQ-029 Outputs instr_out/npc_out combinational from head slot, forced 0 when empty.

Reset
REQ-030 nRST low asynchronously clears pointers, count, halt_seen, halt, storage to 0.
REQ-031 After reset: valid_out 0, full 0, count 0, fetch_stall 0, halt 0, instr_out/npc_out 0.
REQ-032 Reset mid-operation discards all entries; no partial state survives.

Structure
REQ-033 word_t, opcode field width and HALT_OP value come from cpu_types_pkg; no new package types.
REQ-034 Storage is one flat array; no sub-module; optional if_id_queue_if interface mirrors ports.

Verification
REQ-035 Reset, ihit=1 instr=0x8C010004 npc=0x4, deq=0 -> next cycle valid_out=1, instr_out=0x8C010004, count=1.
REQ-036 DEPTH=4, ihit 5 cycles no deq -> count=4, full=1, fetch_stall=1, 5th instr absent; drain yields 4 in order.
REQ-037 Full, ihit=1 and deq=1 same cycle -> count 3, new instr not stored.
REQ-038 Fill 2, flush=1 with ihit=1 -> next cycle count=0, valid_out=0; following ihit stored at slot 0.
REQ-039 Enqueue 0xFFFFFFFF then 0x00000020 -> second rejected, fetch_stall=1; deq HALT -> halt=1 next cycle, stays 1.
REQ-040 10 enq/deq interleaved, DEPTH=4 -> pointers wrap, FIFO order preserved, count never >4 or <0.
